ift_sdffe_pipe: RTL and testbench



---
 rtl/ift_sdffe_pipe.sv | 109 ++++++++++
 tb/tb_ift_sdffe_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ift_sdffe_pipe.sv
// Taint-tracked pipeline of sync-reset, enable-gated registers ($sdffe/$sdffce).
// Define IFT_SDFFE_PIPE_TAINT_CNT_EN to add the TAINT_CNT popcount output.
module ift_sdffe_pipe #(
    parameter int              WIDTH        = 2,
    parameter int              DEPTH        = 3,
    parameter int              TW           = 32,
    parameter logic [WIDTH-1:0] SRST_VAL    = {WIDTH{1'b0}},
    parameter bit              SRST_OVER_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             ARST_N,
    input  logic [TW-1:0]    CLK_t,
    input  logic [WIDTH-1:0] D,
    input  logic [TW-1:0]    D_t,
    input  logic             EN,
    input  logic [TW-1:0]    EN_t,
    input  logic             SRST,
    input  logic [TW-1:0]    SRST_t,
    output logic [WIDTH-1:0] Q,
    output logic [TW-1:0]    Q_t
`ifdef IFT_SDFFE_PIPE_TAINT_CNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] TAINT_CNT
`endif
);

    logic [WIDTH-1:0] q_q  [DEPTH];
    logic [TW-1:0]    qt_q [DEPTH];
    logic [WIDTH-1:0] q_d  [DEPTH];
    logic [TW-1:0]    qt_d [DEPTH];
    logic [WIDTH-1:0] in_d [DEPTH];
    logic [TW-1:0]    in_t [DEPTH];

    logic          do_rst;
    logic          do_shift;
    logic [TW-1:0] rst_t;
    logic [TW-1:0] hold_t;
    logic [TW-1:0] shift_t;

    // The clock taint carries no information into the stored state.
    logic unused_clk_t;
    assign unused_clk_t = ^CLK_t;

    // In $sdffce mode EN gates SRST, so SRST's taint only matters when EN is live.
    always_comb begin
        do_rst   = SRST_OVER_EN ? SRST : (EN & SRST);
        do_shift = EN & ~SRST;
        rst_t    = SRST_OVER_EN ? SRST_t : (SRST_t | EN_t);
        hold_t   = SRST_OVER_EN ? (EN_t | SRST_t) : EN_t;
        shift_t  = EN_t | SRST_t;
    end

    always_comb begin
        in_d[0] = D;
        in_t[0] = D_t;
        for (int k = 1; k < DEPTH; k++) begin
            in_d[k] = q_q[k-1];
            in_t[k] = qt_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            if (do_rst) begin
                q_d[k]  = SRST_VAL;
                qt_d[k] = rst_t;
            end else if (do_shift) begin
                q_d[k]  = in_d[k];
                qt_d[k] = in_t[k] | shift_t;
            end else begin
                q_d[k]  = q_q[k];
                qt_d[k] = qt_q[k] | hold_t;
            end
        end
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            for (int k = 0; k < DEPTH; k++) begin
                q_q[k]  <= '0;
                qt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                q_q[k]  <= q_d[k];
                qt_q[k] <= qt_d[k];
            end
        end
    end

    assign Q   = q_q[DEPTH-1];
    assign Q_t = qt_q[DEPTH-1];

`ifdef IFT_SDFFE_PIPE_TAINT_CNT_EN
    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (|qt_q[k]) cnt = cnt + CW'(1);
        end
    end

    assign TAINT_CNT = cnt;
`endif

endmodule

// File: tb/tb_ift_sdffe_pipe.sv
// Bench for ift_sdffe_pipe: both SRST priority modes side by side against a
// stage-array model, directed scenarios then randomized traffic.
module tb_ift_sdffe_pipe;

    localparam int W  = 2;
    localparam int DP = 3;
    localparam int TW = 32;
    localparam logic [W-1:0] SV = 2'b01;

    logic          CLK = 1'b0;
    logic          ARST_N = 1'b0;
    logic [TW-1:0] CLK_t = '0;
    logic [W-1:0]  D = '0;
    logic [TW-1:0] D_t = '0;
    logic          EN = 1'b0;
    logic [TW-1:0] EN_t = '0;
    logic          SRST = 1'b0;
    logic [TW-1:0] SRST_t = '0;

    logic [W-1:0]  q [2];
    logic [TW-1:0] qt [2];
    logic [1:0]    cnt [2];

    int checks = 0;
    int errors = 0;

    // Model: index 0 = EN gates SRST, index 1 = SRST wins.
    logic [W-1:0]  md [2][DP];
    logic [TW-1:0] mt [2][DP];

    always #5 CLK = ~CLK;

    ift_sdffe_pipe #(
        .WIDTH(W), .DEPTH(DP), .TW(TW), .SRST_VAL(SV), .SRST_OVER_EN(1'b0)
    ) u_ce (
        .CLK(CLK), .ARST_N(ARST_N), .CLK_t(CLK_t),
        .D(D), .D_t(D_t), .EN(EN), .EN_t(EN_t),
        .SRST(SRST), .SRST_t(SRST_t),
        .Q(q[0]), .Q_t(qt[0])
`ifdef IFT_SDFFE_PIPE_TAINT_CNT_EN
        , .TAINT_CNT(cnt[0])
`endif
    );

    ift_sdffe_pipe #(
        .WIDTH(W), .DEPTH(DP), .TW(TW), .SRST_VAL(SV), .SRST_OVER_EN(1'b1)
    ) u_e (
        .CLK(CLK), .ARST_N(ARST_N), .CLK_t(CLK_t),
        .D(D), .D_t(D_t), .EN(EN), .EN_t(EN_t),
        .SRST(SRST), .SRST_t(SRST_t),
        .Q(q[1]), .Q_t(qt[1])
`ifdef IFT_SDFFE_PIPE_TAINT_CNT_EN
        , .TAINT_CNT(cnt[1])
`endif
    );

`ifndef IFT_SDFFE_PIPE_TAINT_CNT_EN
    initial begin
        cnt[0] = '0;
        cnt[1] = '0;
    end
`endif

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < DP; k++) begin
                md[m][k] = '0;
                mt[m][k] = '0;
            end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (m == 1 ? SRST : (EN && SRST)) begin
                for (int k = 0; k < DP; k++) begin
                    md[m][k] = SV;
                    mt[m][k] = (m == 1) ? SRST_t : (SRST_t | EN_t);
                end
            end else if (EN) begin
                for (int k = DP - 1; k > 0; k--) begin
                    md[m][k] = md[m][k-1];
                    mt[m][k] = mt[m][k-1] | EN_t | SRST_t;
                end
                md[m][0] = D;
                mt[m][0] = D_t | EN_t | SRST_t;
            end else begin
                for (int k = 0; k < DP; k++)
                    mt[m][k] |= EN_t | ((m == 1) ? SRST_t : '0);
            end
        end
    endtask

    task automatic compare();
        for (int m = 0; m < 2; m++) begin
            int tc;
            tc = 0;
            for (int k = 0; k < DP; k++) if (mt[m][k] != 0) tc++;
            chk($sformatf("Q[m%0d]", m), 32'(q[m]), 32'(md[m][DP-1]));
            chk($sformatf("Q_t[m%0d]", m), qt[m], mt[m][DP-1]);
`ifdef IFT_SDFFE_PIPE_TAINT_CNT_EN
            chk($sformatf("TAINT_CNT[m%0d]", m), 32'(cnt[m]), 32'(tc));
`endif
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        if (ARST_N) model_edge();
        #1;
        compare();
    endtask

    task automatic drive(logic en, logic sr, logic [W-1:0] d,
                         logic [TW-1:0] dt, logic [TW-1:0] et,
                         logic [TW-1:0] st);
        EN = en; SRST = sr; D = d; D_t = dt; EN_t = et; SRST_t = st;
    endtask

    function automatic logic [TW-1:0] rtaint();
        if ($urandom_range(0, 3) == 0)
            return 32'h1 << $urandom_range(0, 31);
        return '0;
    endfunction

    initial begin
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        compare();
        chk("reset_Q", 32'(q[1]), 32'h0);
        chk("reset_Q_t", qt[1], 32'h0);
        #3 ARST_N = 1'b1;

        // Fill with 2'b11, then drop async reset mid-cycle.
        drive(1, 0, 2'b11, '0, '0, '0);
        repeat (3) cyc();
        chk("fill_Q", 32'(q[1]), 32'h3);
        #2 ARST_N = 1'b0;
        model_clear();
        #1;
        compare();
        chk("arst_Q", 32'(q[1]), 32'h0);
        chk("arst_Q_t", qt[0], 32'h0);
`ifdef IFT_SDFFE_PIPE_TAINT_CNT_EN
        chk("arst_cnt", 32'(cnt[1]), 32'h0);
`endif
        #1 ARST_N = 1'b1;

        // Shift latency: tainted word reaches Q after the third edge.
        drive(1, 0, 2'b10, 32'h1, '0, '0);
        cyc();
`ifdef IFT_SDFFE_PIPE_TAINT_CNT_EN
        chk("lat_cnt1", 32'(cnt[1]), 32'h1);
`endif
        D_t = '0;
        cyc();
        chk("lat_Q_e2", 32'(q[1]), 32'h0);
        cyc();
        chk("lat_Q", 32'(q[1]), 32'h2);
        chk("lat_Q_t", qt[1], 32'h1);

        // Hold accumulates EN taint on every stage.
        drive(0, 0, 2'b00, '0, 32'h2, '0);
        repeat (2) cyc();
        chk("hold_Q", 32'(q[1]), 32'h2);
        chk("hold_Q_t", qt[1], 32'h3);
`ifdef IFT_SDFFE_PIPE_TAINT_CNT_EN
        chk("hold_cnt", 32'(cnt[1]), 32'h3);
`endif

        // SRST wins over a low EN in $sdffe mode only.
        drive(0, 1, 2'b00, '0, '0, 32'h4);
        cyc();
        chk("srst1_Q", 32'(q[1]), 32'h1);
        chk("srst1_Q_t", qt[1], 32'h4);
        chk("srst0_Q_held", 32'(q[0]), 32'h2);

        // $sdffce: SRST ignored while EN=0, then takes effect with EN=1.
        drive(0, 1, 2'b00, '0, 32'h8, 32'h4);
        cyc();
        chk("gate_Q", 32'(q[0]), 32'h2);
        chk("gate_Q_t", qt[0], 32'hb);
        EN = 1'b1;
        cyc();
        chk("gate_en_Q", 32'(q[0]), 32'h1);
        chk("gate_en_Q_t", qt[0], 32'hc);

        // Randomized traffic with sparse taints and occasional async reset.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  W'($urandom), rtaint(), rtaint(), rtaint());
            if ($urandom_range(0, 49) == 0) begin
                #2 ARST_N = 1'b0;
                model_clear();
                #1;
                compare();
                #1 ARST_N = 1'b1;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
